shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Command-driven controller that sits directly upstream of the 8-bit shifter register and drives its S/IN/parallel_in inputs. It accepts one command per valid/ready handshake: load a byte, apply a shift or rotate operation N times, and return the final shifter contents on a valid/ready result port. The shifter's registered output feeds back into this block and is re-applied as IN on every repeat cycle.

## Interface
- CNT_W, 4, width of the repeat count; maximum repeat is 2^CNT_W-1.
- CLK  in  1  rising-edge clock shared with the shifter.
- RST_N  in  1  synchronous, active-low reset; the system ties the shifter's RST to ~RST_N.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command.
- CMD_OP  in  3  shifter opcode: 001 shl, 010 shr, 100 rotl, 101 rotr.
- CMD_COUNT  in  CNT_W  number of operation applications, 0..15.
- CMD_DATA  in  8  initial byte.
- SHF_S  out  3  to shifter S.
- SHF_IN  out  8  to shifter IN.
- SHF_PIN  out  8  to shifter parallel_in.
- SHF_OUT  in  8  from shifter OUT (registered in the shifter).
- RES_VALID  out  1  result present.
- RES_READY  in  1  consumer accepts the result.
- RES_DATA  out  8  final shifter value.
- RES_ERR  out  1  the command carried an illegal opcode.

## Operation
- FSM states: IDLE, LOAD, SHIFT, CAPTURE, DONE.
- IDLE
  - CMD_READY=1, SHF_S=000 (hold).
  - On CMD_VALID&&CMD_READY, latch op, count and data, then go to LOAD.
- LOAD
  - SHF_S=011, SHF_PIN=latched data; the shifter loads at the end of this cycle.
  - If the op is illegal (000, 011, 110, 111): set err and force remaining=0.
  - Next state: SHIFT if remaining!=0, else CAPTURE.
- SHIFT
  - SHF_S=op, SHF_IN=SHF_OUT (combinational feedback); remaining decrements each cycle.
  - Go to CAPTURE in the cycle where remaining==1.
- CAPTURE
  - SHF_S=000.
  - RES_DATA<=SHF_OUT, RES_ERR<=err, RES_VALID<=1; go to DONE.
- DONE
  - RES_VALID=1; RES_DATA and RES_ERR are held stable; SHF_S=000; CMD_READY=0.
  - On RES_READY: RES_VALID<=0, go to IDLE.
- SHF_IN and SHF_PIN are 0 in every state except where listed above.
- Shift semantics are the shifter's: logical shifts fill with 0, rotates wrap bit 7 to bit 0 (rotl) or bit 0 to bit 7 (rotr).
- Count 0 with a legal op returns CMD_DATA unchanged, RES_ERR=0.

## Timing
- Reset (RST_N low at a rising edge):
  - state=IDLE, RES_VALID=0, RES_DATA=0, RES_ERR=0, remaining=0, err=0.
  - SHF_S=000, SHF_IN=0, SHF_PIN=0.
  - CMD_READY is forced 0 while RST_N is low.
- Reset applies from any state, including mid-SHIFT and DONE. Any in-flight command is discarded with no result. The shifter is cleared by the same reset.
- Acceptance cycle t0 → LOAD at t1 → SHIFT at t2..t(1+N) → CAPTURE at t(2+N) → RES_VALID high from t(3+N). Latency is N+3 cycles; illegal ops take 3 cycles.
- Exactly one command is in flight. CMD_READY is high only in IDLE, so throughput is one command per N+4 cycles minimum.
- Result handshake completes on a rising edge with RES_VALID&&RES_READY. CMD_READY rises the following cycle; no command is accepted in the same cycle as result completion.
- The SHF_OUT→SHF_IN path is combinational; it is the only combinational feedback and the block adds no register on it.

## Test plan
- Rotate left: op=100, count=3, data=8'hA5 → shifter sequence A5,4B,96,2D; RES_DATA=8'h2D, RES_ERR=0, RES_VALID at acceptance+6.
- Logical shifts: op=001, count=2, data=8'h81 → 8'h04. Then op=010, count=9, data=8'hFF → 8'h00 (no wrap past zero).
- Full-circle rotate and zero count:
  - op=101, count=8, data=8'h3C → 8'h3C.
  - op=100, count=0, data=8'h77 → 8'h77 at acceptance+3.
- Illegal op: op=110, count=5, data=8'h5A → RES_DATA=8'h5A, RES_ERR=1, latency 3, no SHF_S=110 ever driven.
- Backpressure: hold RES_READY low 4 cycles in DONE → RES_VALID, RES_DATA and RES_ERR stable, CMD_READY=0, SHF_S=000. Release → IDLE next cycle, and a back-to-back command is accepted.
- Reset mid-operation: drop RST_N in the 2nd SHIFT cycle of op=100, count=10 → next edge gives IDLE, all outputs at reset values, no RES_VALID. A following command completes correctly.

Source files
------------

// File: rtl/shift_sequencer.sv
// Command sequencer that drives an external 8-bit shifter (load, then N shift/rotate steps)
// and returns the shifter's final contents on a valid/ready result port.

module shift_sequencer_chk (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_ready,
    input  logic [2:0] i_shf_s,
    input  logic       i_res_valid,
    input  logic       i_res_ready,
    input  logic [7:0] i_res_data,
    input  logic       i_res_err
);

    // The shifter must never see a reserved select code.
    a_shf_s_legal: assert property (@(posedge i_clk)
        (i_shf_s != 3'b110) && (i_shf_s != 3'b111));

    // A new command can only be taken while no result is outstanding.
    a_one_in_flight: assert property (@(posedge i_clk)
        !(i_cmd_ready && i_res_valid));

    // A stalled result holds still until the consumer takes it.
    a_res_stable: assert property (@(posedge i_clk)
        (i_rst_n && i_res_valid && !i_res_ready) |=>
        (i_res_valid && $stable(i_res_data) && $stable(i_res_err)));

endmodule

module shift_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [CNT_W-1:0] i_cmd_count,
    input  logic [7:0]       i_cmd_data,
    output logic [2:0]       o_shf_s,
    output logic [7:0]       o_shf_in,
    output logic [7:0]       o_shf_pin,
    input  logic [7:0]       i_shf_out,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [7:0]       o_res_data,
    output logic             o_res_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROTL = 3'b100;
    localparam logic [2:0] OP_ROTR = 3'b101;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            OP_SHL, OP_SHR, OP_ROTL, OP_ROTR: op_is_legal = 1'b1;
            default:                          op_is_legal = 1'b0;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_remaining;
    logic [7:0]       r_data;
    logic             r_err;
    logic             r_res_valid;
    logic [7:0]       r_res_data;
    logic             r_res_err;
    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_op_legal;

    assign w_cmd_ready = i_rst_n && (r_state == ST_IDLE);
    assign w_op_legal  = op_is_legal(r_op);

    // Next-state decode and shifter control; SHF_IN follows SHF_OUT combinationally while shifting.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        o_shf_s     = OP_HOLD;
        o_shf_in    = 8'h00;
        o_shf_pin   = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid && w_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                o_shf_s   = OP_LOAD;
                o_shf_pin = r_data;
                if (w_op_legal && (r_remaining != CNT_ZERO)) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_SHIFT: begin
                o_shf_s  = r_op;
                o_shf_in = i_shf_out;
                if (r_remaining == CNT_ONE) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (i_res_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch, repeat counter and illegal-op flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_op        <= OP_HOLD;
            r_remaining <= CNT_ZERO;
            r_data      <= 8'h00;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= i_cmd_op;
                        r_remaining <= i_cmd_count;
                        r_data      <= i_cmd_data;
                        r_err       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!w_op_legal) begin
                        r_err       <= 1'b1;
                        r_remaining <= CNT_ZERO;
                    end
                end
                ST_SHIFT: begin
                    r_remaining <= r_remaining - CNT_ONE;
                end
                default: begin
                    r_remaining <= r_remaining;
                end
            endcase
        end
    end

    // Result register: captured once from the shifter, held until the consumer accepts it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= 8'h00;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_CAPTURE: begin
                    r_res_valid <= 1'b1;
                    r_res_data  <= i_shf_out;
                    r_res_err   <= r_err;
                end
                ST_DONE: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_res_valid <= r_res_valid;
                end
            endcase
        end
    end

    assign o_cmd_ready = w_cmd_ready;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_err   = r_res_err;

    shift_sequencer_chk u_chk (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_ready (o_cmd_ready),
        .i_shf_s     (o_shf_s),
        .i_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .i_res_data  (o_res_data),
        .i_res_err   (o_res_err)
    );

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; includes a behavioural model of the downstream 8-bit shifter.

module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_count;
    logic [7:0] cmd_data;
    logic [2:0] shf_s;
    logic [7:0] shf_in;
    logic [7:0] shf_pin;
    logic [7:0] shf_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int bad_s_count  = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.CNT_W(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_count (cmd_count),
        .i_cmd_data  (cmd_data),
        .o_shf_s     (shf_s),
        .o_shf_in    (shf_in),
        .o_shf_pin   (shf_pin),
        .i_shf_out   (shf_out),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_data  (res_data),
        .o_res_err   (res_err)
    );

    // Downstream shifter: registered output, reset together with the sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shf_out <= 8'h00;
        end else begin
            case (shf_s)
                3'b001:  shf_out <= {shf_in[6:0], 1'b0};
                3'b010:  shf_out <= {1'b0, shf_in[7:1]};
                3'b011:  shf_out <= shf_pin;
                3'b100:  shf_out <= {shf_in[6:0], shf_in[7]};
                3'b101:  shf_out <= {shf_in[0], shf_in[7:1]};
                default: shf_out <= shf_out;
            endcase
        end
    end

    always @(posedge clk) begin
        if (shf_s == 3'b110 || shf_s == 3'b111) bad_s_count <= bad_s_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] d,
                           output int lat, output logic [7:0] rd, output logic re, output bit to);
        int n;
        to = 1'b0;
        cmd_op = op; cmd_count = cnt; cmd_data = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        if (!cmd_ready) to = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 40) begin tick(); lat++; end
        if (!res_valid) to = 1'b1;
        rd = res_data;
        re = res_err;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        tests_run++;
        if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
        tests_run++;
        if ({shf_s, shf_in, shf_pin} !== 19'h0) begin tests_failed++;
            $display("FAIL reset_shf: got s=%b in=%h pin=%h expected all 0", shf_s, shf_in, shf_pin); end
        tests_run++;
        if ({res_valid, res_err, res_data} !== 10'h0) begin tests_failed++;
            $display("FAIL reset_res: got v=%b e=%b d=%h expected all 0", res_valid, res_err, res_data); end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_rotate_left();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hA5; exp_seq[1] = 8'h4B; exp_seq[2] = 8'h96; exp_seq[3] = 8'h2D;
        cmd_op = 3'b100; cmd_count = 4'd3; cmd_data = 8'hA5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if ({shf_s, shf_pin, cmd_ready} !== {3'b011, 8'hA5, 1'b0}) begin tests_failed++;
            $display("FAIL rotl_load: got s=%b pin=%h rdy=%b expected s=011 pin=a5 rdy=0", shf_s, shf_pin, cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({shf_out, shf_s, shf_in} !== {exp_seq[i], 3'b100, exp_seq[i]}) begin tests_failed++;
                $display("FAIL rotl_shift%0d: got out=%h s=%b in=%h expected out=%h s=100 in=%h",
                         i, shf_out, shf_s, shf_in, exp_seq[i], exp_seq[i]); end
        end
        tick();
        tests_run++;
        if ({shf_out, shf_s, shf_in, res_valid} !== {exp_seq[3], 3'b000, 8'h00, 1'b0}) begin tests_failed++;
            $display("FAIL rotl_capture: got out=%h s=%b in=%h v=%b expected out=2d s=000 in=00 v=0",
                     shf_out, shf_s, shf_in, res_valid); end
        tick();
        tests_run++;
        if ({res_valid, res_err, res_data} !== {1'b1, 1'b0, 8'h2D}) begin tests_failed++;
            $display("FAIL rotl_result: got v=%b e=%b d=%h expected v=1 e=0 d=2d", res_valid, res_err, res_data); end
        release_result();
    endtask

    task automatic test_logical();
        int lat; logic [7:0] rd; logic re; bit to;
        run_cmd(3'b001, 4'd2, 8'h81, lat, rd, re, to);
        tests_run++;
        if ({to, re, rd} !== {1'b0, 1'b0, 8'h04} || lat != 5) begin tests_failed++;
            $display("FAIL shl_2: got to=%b e=%b d=%h lat=%0d expected to=0 e=0 d=04 lat=5", to, re, rd, lat); end
        release_result();
        run_cmd(3'b010, 4'd9, 8'hFF, lat, rd, re, to);
        tests_run++;
        if ({to, re, rd} !== {1'b0, 1'b0, 8'h00} || lat != 12) begin tests_failed++;
            $display("FAIL shr_9: got to=%b e=%b d=%h lat=%0d expected to=0 e=0 d=00 lat=12", to, re, rd, lat); end
        release_result();
    endtask

    task automatic test_full_circle_and_zero();
        int lat; logic [7:0] rd; logic re; bit to;
        run_cmd(3'b101, 4'd8, 8'h3C, lat, rd, re, to);
        tests_run++;
        if ({to, re, rd} !== {1'b0, 1'b0, 8'h3C} || lat != 11) begin tests_failed++;
            $display("FAIL rotr_8: got to=%b e=%b d=%h lat=%0d expected to=0 e=0 d=3c lat=11", to, re, rd, lat); end
        release_result();
        run_cmd(3'b100, 4'd0, 8'h77, lat, rd, re, to);
        tests_run++;
        if ({to, re, rd} !== {1'b0, 1'b0, 8'h77} || lat != 3) begin tests_failed++;
            $display("FAIL rotl_0: got to=%b e=%b d=%h lat=%0d expected to=0 e=0 d=77 lat=3", to, re, rd, lat); end
        release_result();
        run_cmd(3'b101, 4'd1, 8'h01, lat, rd, re, to);
        tests_run++;
        if ({to, re, rd} !== {1'b0, 1'b0, 8'h80} || lat != 4) begin tests_failed++;
            $display("FAIL rotr_1: got to=%b e=%b d=%h lat=%0d expected to=0 e=0 d=80 lat=4", to, re, rd, lat); end
        release_result();
    endtask

    task automatic test_illegal_op();
        int lat; logic [7:0] rd; logic re; bit to; int bad_before;
        bad_before = bad_s_count;
        run_cmd(3'b110, 4'd5, 8'h5A, lat, rd, re, to);
        tests_run++;
        if ({to, re, rd} !== {1'b0, 1'b1, 8'h5A} || lat != 3) begin tests_failed++;
            $display("FAIL illegal_110: got to=%b e=%b d=%h lat=%0d expected to=0 e=1 d=5a lat=3", to, re, rd, lat); end
        tests_run++;
        if (bad_s_count != bad_before) begin tests_failed++;
            $display("FAIL illegal_s_driven: got %0d reserved S cycles expected 0", bad_s_count - bad_before); end
        release_result();
        run_cmd(3'b001, 4'd1, 8'h11, lat, rd, re, to);
        tests_run++;
        if ({to, re, rd} !== {1'b0, 1'b0, 8'h22}) begin tests_failed++;
            $display("FAIL err_cleared: got to=%b e=%b d=%h expected to=0 e=0 d=22", to, re, rd); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] rd; logic re; bit to;
        run_cmd(3'b101, 4'd1, 8'h01, lat, rd, re, to);
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({res_valid, res_err, res_data, cmd_ready, shf_s} !== {1'b1, 1'b0, 8'h80, 1'b0, 3'b000}) begin
                tests_failed++;
                $display("FAIL stall%0d: got v=%b e=%b d=%h rdy=%b s=%b expected v=1 e=0 d=80 rdy=0 s=000",
                         i, res_valid, res_err, res_data, cmd_ready, shf_s);
            end
        end
        cmd_op = 3'b001; cmd_count = 4'd1; cmd_data = 8'h40; cmd_valid = 1'b1;
        res_ready = 1'b1;
        tests_run++;
        if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_during_done: got %b expected 0", cmd_ready); end
        tick();
        res_ready = 1'b0;
        tests_run++;
        if ({res_valid, cmd_ready} !== 2'b01) begin tests_failed++;
            $display("FAIL after_release: got v=%b rdy=%b expected v=0 rdy=1", res_valid, cmd_ready); end
        run_cmd(3'b001, 4'd1, 8'h40, lat, rd, re, to);
        tests_run++;
        if ({to, re, rd} !== {1'b0, 1'b0, 8'h80} || lat != 4) begin tests_failed++;
            $display("FAIL b2b_cmd: got to=%b e=%b d=%h lat=%0d expected to=0 e=0 d=80 lat=4", to, re, rd, lat); end
        release_result();
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [7:0] rd; logic re; bit to; bit seen;
        cmd_op = 3'b100; cmd_count = 4'd10; cmd_data = 8'h01; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        tests_run++;
        if (shf_s !== 3'b100) begin tests_failed++; $display("FAIL mid_shift_state: got s=%b expected 100", shf_s); end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if ({cmd_ready, shf_s, shf_in, shf_pin, res_valid, res_err, res_data} !== 30'h0) begin tests_failed++;
            $display("FAIL mid_reset_outputs: got rdy=%b s=%b in=%h pin=%h v=%b e=%b d=%h expected all 0",
                     cmd_ready, shf_s, shf_in, shf_pin, res_valid, res_err, res_data); end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_idle: got rdy=%b expected 1", cmd_ready); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (res_valid) seen = 1'b1;
            tick();
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_no_result: got valid seen=%b expected 0", seen); end
        run_cmd(3'b100, 4'd2, 8'h81, lat, rd, re, to);
        tests_run++;
        if ({to, re, rd} !== {1'b0, 1'b0, 8'h06} || lat != 5) begin tests_failed++;
            $display("FAIL post_reset_cmd: got to=%b e=%b d=%h lat=%0d expected to=0 e=0 d=06 lat=5", to, re, rd, lat); end
        release_result();
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_count = 4'd0;
        cmd_data = 8'h00; res_ready = 1'b0;
        test_reset();
        test_rotate_left();
        test_logical();
        test_full_circle_and_zero();
        test_illegal_op();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
